// File: rtl/wr_burst_pkg.sv
// Shared definitions for the DDR write-burst controller: FSM state encoding,
// default geometry constants and a small state-decode helper.
package wr_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } wr_state_e;

  localparam int DEF_BURST_LEN   = 64;
  localparam int DEF_FRAME_WORDS = 393216;  // 1024x768 pixels, 32 bit, packed two per 64-bit word
  localparam int DEF_BASE_ADDR   = 0;

  // True in the states where the DDR master may pull words from the FIFO.
  function automatic logic state_is_active(input wr_state_e s);
    return (s == ST_REQ) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/wr_burst_addr_gen.sv
// Frame-buffer word address generator for wr_burst_ctrl.
// Owns the burst start address, advances it by the finished burst length,
// wraps at the end of the frame buffer and handles frame_start pulses that
// arrive while a burst is in flight (held pending until the burst completes).
module wr_burst_addr_gen
  import wr_burst_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_idle,
  input  logic              in_done,
  input  logic [7:0]        burst_len,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(BASE_ADDR + FRAME_WORDS);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   sum_s;

  // Next address and pending-restart flag.
  always_comb begin
    addr_d = addr_q;
    pend_d = pend_q;
    sum_s  = {1'b0, addr_q} + (ADDR_W+1)'(burst_len);
    if (in_idle) begin
      // No burst in flight: a frame start rewinds straight away.
      if (frame_start) begin
        addr_d = BASE;
      end else begin
        addr_d = addr_q;
      end
    end else if (in_done) begin
      // Burst complete: a pending or coincident restart wins over the advance.
      if (pend_q || frame_start) begin
        addr_d = BASE;
      end else if (sum_s >= LIMIT) begin
        addr_d = BASE;
      end else begin
        addr_d = sum_s[ADDR_W-1:0];
      end
      pend_d = 1'b0;
    end else begin
      // Burst in flight: remember the restart for the end of the burst.
      if (frame_start) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  // Address and pending-flag registers.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/wr_burst_ctrl.sv
// DDR write-burst controller: watches the write-FIFO read-side level, issues
// BURST_LEN-word write bursts to the DDR write master, forwards the master's
// per-word data requests to the FIFO read enable and flags protocol errors.
// Optional feature macro: WR_BURST_FLUSH_EN adds a frame_end input that
// drains a final partial burst of whatever the FIFO still holds.
module wr_burst_ctrl
  import wr_burst_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int ADDR_W      = 28,
  parameter int LEVEL_W     = 10,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic               mem_clk,
  input  logic               rst_n,
  input  logic               frame_start,
`ifdef WR_BURST_FLUSH_EN
  input  logic               frame_end,
`endif
  input  logic [LEVEL_W-1:0] rd_water_level,
  output logic               rd_en,
  output logic               wr_burst_req,
  output logic [7:0]         wr_burst_len,
  output logic [ADDR_W-1:0]  wr_burst_addr,
  input  logic               wr_burst_data_req,
  input  logic               wr_burst_finish,
  output logic               busy,
  output logic               err
);

  localparam logic [7:0] FULL_LEN = 8'(BURST_LEN);

  wr_state_e  state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       rd_en_s;
  logic       level_full_s;
`ifdef WR_BURST_FLUSH_EN
  logic       flush_q, flush_d;
  logic       level_some_s;
`endif

  assign level_full_s = 32'(rd_water_level) >= 32'(BURST_LEN);
`ifdef WR_BURST_FLUSH_EN
  assign level_some_s = (rd_water_level != {LEVEL_W{1'b0}}) && !level_full_s;
`endif

  // Next-state, word counting, read-enable forwarding and error detection.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_en_s = 1'b0;
`ifdef WR_BURST_FLUSH_EN
    flush_d = flush_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wr_burst_data_req || wr_burst_finish) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (frame_start) begin
          // The address is being rewound this cycle; start on the next one.
          state_d = ST_IDLE;
        end else if (level_full_s) begin
          state_d = ST_REQ;
          len_d   = FULL_LEN;
          cnt_d   = 8'd0;
`ifdef WR_BURST_FLUSH_EN
        end else if (flush_q && level_some_s) begin
          state_d = ST_REQ;
          len_d   = 8'(rd_water_level);
          cnt_d   = 8'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
`ifdef WR_BURST_FLUSH_EN
        if (flush_q && (rd_water_level == {LEVEL_W{1'b0}})) begin
          flush_d = 1'b0;
        end else begin
          flush_d = flush_q;
        end
`endif
      end
      ST_REQ, ST_DATA: begin
        if (wr_burst_data_req) begin
          if (cnt_q < len_q) begin
            rd_en_s = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            // Over-run: the FIFO is not read past the burst length.
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (wr_burst_finish) begin
          state_d = ST_DONE;
          if (cnt_d != len_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_d;
          end
        end else if ((state_q == ST_REQ) && wr_burst_data_req) begin
          state_d = ST_DATA;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef WR_BURST_FLUSH_EN
        flush_d = 1'b0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef WR_BURST_FLUSH_EN
    if (frame_end) begin
      flush_d = 1'b1;
    end else begin
      flush_d = flush_d;
    end
`endif
  end

  // Controller state registers.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef WR_BURST_FLUSH_EN
  // Flush request flag raised by frame_end.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush_d;
    end
  end
`endif

  wr_burst_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_gen (
    .mem_clk     (mem_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .in_idle     (state_q == ST_IDLE),
    .in_done     (state_q == ST_DONE),
    .burst_len   (len_q),
    .addr        (wr_burst_addr)
  );

  assign rd_en        = rd_en_s && state_is_active(state_q);
  assign wr_burst_req = (state_q == ST_REQ);
  assign wr_burst_len = len_q;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Self-checking bench for wr_burst_ctrl (default parameters).
module tb_wr_burst_ctrl;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        fstart;
  logic [9:0]  level;
  logic        rd_en;
  logic        wr_burst_req;
  logic [7:0]  wr_burst_len;
  logic [27:0] wr_burst_addr;
  logic        dreq;
  logic        fin;
  logic        busy;
  logic        err;
`ifdef WR_BURST_FLUSH_EN
  logic        fe = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int exp_addr;

  typedef struct {
    logic [9:0]  level;
    logic        dreq;
    logic        fin;
    logic        fs;
    logic        req;
    logic        rd;
    logic        busy;
    logic        err;
    logic [7:0]  len;
    logic [27:0] addr;
  } vec_t;

  vec_t tbl [8];

  wr_burst_ctrl dut (
    .mem_clk           (mem_clk),
    .rst_n             (rst_n),
    .frame_start       (fstart),
`ifdef WR_BURST_FLUSH_EN
    .frame_end         (fe),
`endif
    .rd_water_level    (level),
    .rd_en             (rd_en),
    .wr_burst_req      (wr_burst_req),
    .wr_burst_len      (wr_burst_len),
    .wr_burst_addr     (wr_burst_addr),
    .wr_burst_data_req (dreq),
    .wr_burst_finish   (fin),
    .busy              (busy),
    .err               (err)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and let outputs settle.
  task automatic cyc(input logic [9:0] lvl, input logic dr, input logic fi, input logic fs);
    @(negedge mem_clk);
    level  = lvl;
    dreq   = dr;
    fin    = fi;
    fstart = fs;
    #1;
    if (rd_en === 1'b1) rd_cnt++;
  endtask

  task automatic run_words(input int n);
    for (int i = 0; i < n; i++) cyc(10'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    fstart = 1'b0;
    level  = 10'd0;
    dreq   = 1'b0;
    fin    = 1'b0;

    // reset state
    repeat (2) @(negedge mem_clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req",  32'(wr_burst_req), 32'd0);
    chk("rst_len",  32'(wr_burst_len), 32'd0);
    chk("rst_addr", 32'(wr_burst_addr), 32'd0);
    chk("rst_err",  32'(err), 32'd0);
    @(negedge mem_clk);
    rst_n = 1'b1;

    //            level  dreq  fin   fs   | req   rd    busy  err   len    addr
    tbl[0] = '{10'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  28'd0};
    tbl[1] = '{10'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  28'd0};
    tbl[2] = '{10'd64, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  28'd0};
    tbl[3] = '{10'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  28'd0};
    tbl[4] = '{10'd64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd64, 28'd0};
    tbl[5] = '{10'd64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd64, 28'd0};
    tbl[6] = '{10'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd64, 28'd0};
    tbl[7] = '{10'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd64, 28'd0};

    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].level, tbl[i].dreq, tbl[i].fin, tbl[i].fs);
      chk($sformatf("v%0d_req", i),  32'(wr_burst_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_rd", i),   32'(rd_en), 32'(tbl[i].rd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_err", i),  32'(err), 32'(tbl[i].err));
      chk($sformatf("v%0d_len", i),  32'(wr_burst_len), 32'(tbl[i].len));
      chk($sformatf("v%0d_addr", i), 32'(wr_burst_addr), 32'(tbl[i].addr));
    end

    // burst 1: finish the 64 words
    run_words(62);
    chk("b1_rd_pulses", 32'(rd_cnt), 32'd64);
    cyc(10'd0, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b1_done_busy", 32'(busy), 32'd1);
    chk("b1_done_req", 32'(wr_burst_req), 32'd0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b1_addr", 32'(wr_burst_addr), 32'd64);
    chk("b1_err", 32'(err), 32'd0);
    chk("b1_idle", 32'(busy), 32'd0);
    chk("b1_rd_total", 32'(rd_cnt), 32'd64);

    // burst 2: plain
    cyc(10'd64, 1'b0, 1'b0, 1'b0);
    run_words(64);
    cyc(10'd0, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b2_addr", 32'(wr_burst_addr), 32'd128);

    // burst 3: frame_start during DATA
    cyc(10'd64, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b3_req", 32'(wr_burst_req), 32'd1);
    chk("b3_addr_start", 32'(wr_burst_addr), 32'd128);
    run_words(10);
    cyc(10'd0, 1'b1, 1'b0, 1'b1);
    run_words(53);
    cyc(10'd0, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b3_addr_done", 32'(wr_burst_addr), 32'd128);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b3_addr_restart", 32'(wr_burst_addr), 32'd0);
    chk("b3_err", 32'(err), 32'd0);

    // burst 4: 65th data request
    cyc(10'd64, 1'b0, 1'b0, 1'b0);
    run_words(64);
    cyc(10'd0, 1'b1, 1'b0, 1'b0);
    chk("b4_extra_rd", 32'(rd_en), 32'd0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b4_err", 32'(err), 32'd1);
    cyc(10'd0, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("b4_addr", 32'(wr_burst_addr), 32'd64);

    // short bursts (finish in REQ) to walk the address up to the frame end
    for (int k = 0; k < 6142; k++) begin
      cyc(10'd64, 1'b0, 1'b0, 1'b0);
      cyc(10'd0, 1'b0, 1'b1, 1'b0);
      cyc(10'd0, 1'b0, 1'b0, 1'b0);
    end

    // wrap burst
    cyc(10'd64, 1'b0, 1'b0, 1'b0);
    chk("wrap_addr_start", 32'(wr_burst_addr), 32'd393152);
    chk("wrap_idle", 32'(busy), 32'd0);
    run_words(64);
    cyc(10'd0, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_addr", 32'(wr_burst_addr), 32'd0);
    exp_addr = 0;

`ifdef WR_BURST_FLUSH_EN
    // partial burst drained by frame_end
    @(negedge mem_clk);
    level = 10'd10; fe = 1'b1; dreq = 1'b0; fin = 1'b0; fstart = 1'b0;
    #1;
    @(negedge mem_clk);
    fe = 1'b0;
    #1;
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("fl_req", 32'(wr_burst_req), 32'd1);
    chk("fl_len", 32'(wr_burst_len), 32'd10);
    run_words(10);
    cyc(10'd0, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("fl_addr", 32'(wr_burst_addr), 32'd10);
    chk("fl_idle", 32'(busy), 32'd0);
    exp_addr = 10;
`endif

    // reset in the middle of DATA
    cyc(10'd64, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    exp_addr = exp_addr + 64;
    cyc(10'd64, 1'b0, 1'b0, 1'b0);
    run_words(5);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_addr", 32'(wr_burst_addr), 32'(exp_addr));
    @(negedge mem_clk);
    dreq  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(wr_burst_addr), 32'd0);
    chk("arst_req",  32'(wr_burst_req), 32'd0);
    chk("arst_rd",   32'(rd_en), 32'd0);
    chk("arst_len",  32'(wr_burst_len), 32'd0);
    chk("arst_err",  32'(err), 32'd0);
    dreq = 1'b0;
    @(negedge mem_clk);
    rst_n = 1'b1;
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_addr", 32'(wr_burst_addr), 32'd0);
    chk("post_err",  32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
